// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-to-decode and decode-to-execute handshake bundle.
// The slave modport is the decode side; the master modport is the fetch/execute environment.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [XLEN-1:0] out_imm;
    logic            out_reg_write;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7b5,
               out_rd, out_rs1, out_rs2, out_rs1_val, out_rs2_val, out_imm,
               out_reg_write, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7b5,
               out_rd, out_rs1, out_rs2, out_rs1_val, out_rs2_val, out_imm,
               out_reg_write, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: field/immediate decode, register file, registered bundle.
// Owns the integer register file; writeback writes it and bypasses into the capture cycle.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    decode_stage_if.slave   bus,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   capture;

    logic [XLEN-1:0] regs_q [NREGS];

    logic [31:0]     instr;
    logic [6:0]      opcode_c;
    logic [4:0]      rd_c, rs1_c, rs2_c;
    logic [XLEN-1:0] imm_c;
    logic            writes_rd_c;
    logic            illegal_c;
    logic [XLEN-1:0] rs1_val_c, rs2_val_c;

    logic [XLEN-1:0] pc_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0] rs1_val_q, rs2_val_q;
    logic [XLEN-1:0] imm_q;
    logic            reg_write_q;
    logic            illegal_q;

    assign instr    = bus.in_instr;
    assign opcode_c = instr[6:0];
    assign rd_c     = instr[11:7];
    assign rs1_c    = instr[19:15];
    assign rs2_c    = instr[24:20];

    assign bus.in_ready = flush_i | (state_q == S_EMPTY) | bus.out_ready;
    assign capture      = bus.in_valid & bus.in_ready & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush dominates both a new capture and a stalled bundle.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else if (capture) begin
            state_d = S_FULL;
        end else if (bus.out_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_comb begin
        imm_c       = '0;
        writes_rd_c = 1'b0;
        illegal_c   = 1'b0;
        unique case (opcode_c)
            OPC_LUI, OPC_AUIPC: begin
                imm_c       = {instr[31:12], 12'b0};
                writes_rd_c = 1'b1;
            end
            OPC_JAL: begin
                imm_c       = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
                writes_rd_c = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                imm_c       = {{(XLEN-12){instr[31]}}, instr[31:20]};
                writes_rd_c = 1'b1;
            end
            OPC_STORE: begin
                imm_c = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                imm_c = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            end
            OPC_OP: begin
                writes_rd_c = 1'b1;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

    // Write-through: a writeback in the capture cycle is visible to the bundle.
    always_comb begin
        rs1_val_c = regs_q[rs1_c];
        rs2_val_c = regs_q[rs2_c];
        if (wb_en_i && (wb_rd_i == rs1_c)) begin
            rs1_val_c = wb_data_i;
        end
        if (wb_en_i && (wb_rd_i == rs2_c)) begin
            rs2_val_c = wb_data_i;
        end
        if (rs1_c == 5'd0) begin
            rs1_val_c = '0;
        end
        if (rs2_c == 5'd0) begin
            rs2_val_c = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // Fields only load on capture, so a stall holds the operand values as read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (capture) begin
            pc_q        <= bus.in_pc;
            opcode_q    <= opcode_c;
            funct3_q    <= instr[14:12];
            funct7b5_q  <= instr[30];
            rd_q        <= rd_c;
            rs1_q       <= rs1_c;
            rs2_q       <= rs2_c;
            rs1_val_q   <= rs1_val_c;
            rs2_val_q   <= rs2_val_c;
            imm_q       <= imm_c;
            reg_write_q <= writes_rd_c & (rd_c != 5'd0);
            illegal_q   <= illegal_c;
        end
    end

    assign bus.out_valid     = (state_q == S_FULL);
    assign bus.out_pc        = pc_q;
    assign bus.out_opcode    = opcode_q;
    assign bus.out_funct3    = funct3_q;
    assign bus.out_funct7b5  = funct7b5_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_rs1_val   = rs1_val_q;
    assign bus.out_rs2_val   = rs2_val_q;
    assign bus.out_imm       = imm_q;
    assign bus.out_reg_write = reg_write_q;
    assign bus.out_illegal   = illegal_q;
endmodule
